// File: rtl/data_path_pkg.sv
// data_path_pkg
//   Shared definitions for the mini-SRC single-bus datapath: data widths,
//   instruction-register field positions, ALU opcode encodings and the
//   default RAM depth.
//   No ports (package).
package data_path_pkg;

    localparam int DATA_W            = 32;
    localparam int Z_W               = 2 * DATA_W;
    localparam int REG_COUNT         = 16;
    localparam int MEM_DEPTH_DEFAULT = 512;

    // IR field bit positions
    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 27;
    localparam int RA_MSB  = 26;
    localparam int RA_LSB  = 23;
    localparam int RB_MSB  = 22;
    localparam int RB_LSB  = 19;
    localparam int RC_MSB  = 18;
    localparam int RC_LSB  = 15;
    localparam int C_MSB   = 18;

    typedef enum logic [4:0] {
        OP_LD   = 5'b00000,
        OP_LDI  = 5'b00001,
        OP_ST   = 5'b00010,
        OP_ADD  = 5'b00011,
        OP_SUB  = 5'b00100,
        OP_AND  = 5'b00101,
        OP_OR   = 5'b00110,
        OP_ROR  = 5'b00111,
        OP_ROL  = 5'b01000,
        OP_SHR  = 5'b01001,
        OP_SHRA = 5'b01010,
        OP_SHL  = 5'b01011,
        OP_ADDI = 5'b01100,
        OP_ANDI = 5'b01101,
        OP_ORI  = 5'b01110,
        OP_DIV  = 5'b01111,
        OP_MUL  = 5'b10000,
        OP_NEG  = 5'b10001,
        OP_NOT  = 5'b10010
    } opcode_e;

    // Sign-extend the 19-bit constant field of an instruction word.
    function automatic logic [DATA_W-1:0] sext_c(input logic [DATA_W-1:0] ir);
        return {{(DATA_W - C_MSB - 1){ir[C_MSB]}}, ir[C_MSB:0]};
    endfunction

endpackage

// File: rtl/data_path_alu.sv
// data_path_alu
//   Combinational ALU of the datapath. Operand A is the Y register, operand
//   B is the shared bus. Produces a 64-bit result destined for Z; 32-bit
//   operations leave the upper half zero.
//   Ports:
//     y_i      [31:0]  operand A (Y register)
//     bus_i    [31:0]  operand B (bus)
//     opcode_i [4:0]   operation select
//     inc_pc_i         forces result = {32'b0, B+1} regardless of opcode
//     z_o      [63:0]  result
module data_path_alu
    import data_path_pkg::*;
(
    input  logic [DATA_W-1:0] y_i,
    input  logic [DATA_W-1:0] bus_i,
    input  logic [4:0]        opcode_i,
    input  logic              inc_pc_i,
    output logic [Z_W-1:0]    z_o
);

    logic signed [DATA_W-1:0] y_s;
    logic signed [DATA_W-1:0] b_s;
    logic signed [Z_W-1:0]    y_ext;
    logic signed [Z_W-1:0]    b_ext;
    logic signed [Z_W-1:0]    prod;
    logic [Z_W-1:0]           div_res;
    logic [4:0]               amt;
    logic [DATA_W-1:0]        lo;
    logic [DATA_W-1:0]        hi;

    function automatic logic [DATA_W-1:0] rotl(input logic [DATA_W-1:0] a,
                                               input logic [4:0] n);
        logic [Z_W-1:0] t;
        t = {a, a} << n;
        return t[Z_W-1:DATA_W];
    endfunction

    function automatic logic [DATA_W-1:0] rotr(input logic [DATA_W-1:0] a,
                                               input logic [4:0] n);
        logic [Z_W-1:0] t;
        t = {a, a} >> n;
        return t[DATA_W-1:0];
    endfunction

    // Signed divide packed as {remainder, quotient}; a zero divisor yields 0.
    function automatic logic [Z_W-1:0] sdiv(input logic signed [DATA_W-1:0] a,
                                            input logic signed [DATA_W-1:0] b);
        logic signed [DATA_W-1:0] q;
        logic signed [DATA_W-1:0] r;
        if (b == '0) begin
            return '0;
        end
        q = a / b;
        r = a % b;
        return {r, q};
    endfunction

    assign y_s     = y_i;
    assign b_s     = bus_i;
    assign y_ext   = {{DATA_W{y_i[DATA_W-1]}}, y_i};
    assign b_ext   = {{DATA_W{bus_i[DATA_W-1]}}, bus_i};
    assign prod    = y_ext * b_ext;
    assign div_res = sdiv(y_s, b_s);
    assign amt     = bus_i[4:0];

    always_comb begin
        hi = '0;
        lo = y_i + bus_i;
        if (inc_pc_i) begin
            lo = bus_i + 32'd1;
        end else begin
            case (opcode_i)
                OP_SUB:          lo = y_i - bus_i;
                OP_AND, OP_ANDI: lo = y_i & bus_i;
                OP_OR,  OP_ORI:  lo = y_i | bus_i;
                OP_ROR:          lo = rotr(y_i, amt);
                OP_ROL:          lo = rotl(y_i, amt);
                OP_SHR:          lo = y_i >> amt;
                OP_SHRA:         lo = y_s >>> amt;
                OP_SHL:          lo = y_i << amt;
                OP_DIV:          {hi, lo} = div_res;
                OP_MUL:          {hi, lo} = prod;
                OP_NEG:          lo = 32'd0 - bus_i;
                OP_NOT:          lo = ~bus_i;
                // ld/ldi/st/add/addi and any unlisted or unknown code add
                default:         lo = y_i + bus_i;
            endcase
        end
    end

    assign z_o = {hi, lo};

endmodule

// File: rtl/data_path.sv
// data_path
//   Single-bus 32-bit mini-SRC datapath: R0-R15, PC, IR, MAR, MDR, HI, LO,
//   Y, 64-bit Z, input port and an instruction/data RAM joined by one
//   shared bus. Every enable is driven externally each control step.
//   Register loads happen on the falling clock edge (mid-step); the RAM and
//   the input port act on the rising edge.
//   Ports:
//     clock, clear           clock; asynchronous active-low reset
//     read, write            RAM read (MDR source, RAM output update) / write
//     Gra, Grb, Grc          select Ra/Rb/Rc field of IR
//     Rin, Rout, BAout       load / drive selected register (BAout: R0 reads 0)
//     HIin/HIout, LOin/LOout HI/LO load and drive
//     Zin, Zhighout, Zlowout load Z from ALU; drive Z[63:32] / Z[31:0]
//     Yin                    load Y from bus
//     MDRin, MDRout, MARin   MDR load/drive, MAR load
//     PCin, PCout, IRin      PC load/drive, IR load
//     IncPC                  ALU produces bus+1
//     Cout                   drive sign-extended IR[18:0]
//     opcode [4:0]           ALU operation
//     Inport_In [31:0]       external input data
//     Strobe, InPortout      capture input data / drive in-port register
module data_path
    import data_path_pkg::*;
#(
    parameter int    MEM_DEPTH = MEM_DEPTH_DEFAULT,
    parameter string INIT_FILE = "memory.hex"
) (
    input  logic              clock,
    input  logic              clear,
    input  logic              read,
    input  logic              write,
    input  logic              Gra,
    input  logic              Grb,
    input  logic              Grc,
    input  logic              Rin,
    input  logic              Rout,
    input  logic              BAout,
    input  logic              HIin,
    input  logic              HIout,
    input  logic              LOin,
    input  logic              LOout,
    input  logic              Zin,
    input  logic              Zhighout,
    input  logic              Zlowout,
    input  logic              Yin,
    input  logic              MDRin,
    input  logic              MDRout,
    input  logic              MARin,
    input  logic              PCin,
    input  logic              PCout,
    input  logic              IRin,
    input  logic              IncPC,
    input  logic              Cout,
    input  logic [4:0]        opcode,
    input  logic [DATA_W-1:0] Inport_In,
    input  logic              Strobe,
    input  logic              InPortout
);

    localparam int AW = $clog2(MEM_DEPTH);

    logic [DATA_W-1:0] rf_q [REG_COUNT];
    logic [DATA_W-1:0] pc_q;
    logic [DATA_W-1:0] ir_q;
    logic [DATA_W-1:0] mar_q;
    logic [DATA_W-1:0] mdr_q;
    logic [DATA_W-1:0] hi_q;
    logic [DATA_W-1:0] lo_q;
    logic [DATA_W-1:0] y_q;
    logic [Z_W-1:0]    z_q;
    logic [DATA_W-1:0] inport_q;
    logic [DATA_W-1:0] mem_out_q;
    logic [DATA_W-1:0] mem [MEM_DEPTH];

    logic [3:0]        sel;
    logic [DATA_W-1:0] reg_val;
    logic [DATA_W-1:0] c_sext;
    logic [DATA_W-1:0] bus;
    logic [DATA_W-1:0] mdr_d;
    logic [Z_W-1:0]    alu_z;
    logic [AW-1:0]     addr;

    // Opcode bits of IR are decoded by the external control unit, and MAR
    // bits above the RAM address width are not used here.
    logic unused_bits;
    assign unused_bits = ^{ir_q[OPC_MSB:OPC_LSB], mar_q[DATA_W-1:AW]};

    assign addr   = mar_q[AW-1:0];
    assign c_sext = sext_c(ir_q);

    // Select-and-encode: enabled fields are ORed into one register index.
    always_comb begin
        sel = '0;
        if (Gra) sel = sel | ir_q[RA_MSB:RA_LSB];
        if (Grb) sel = sel | ir_q[RB_MSB:RB_LSB];
        if (Grc) sel = sel | ir_q[RC_MSB:RC_LSB];
    end

    // Base-address reads treat R0 as a hard zero.
    assign reg_val = (BAout && sel == 4'd0) ? '0 : rf_q[sel];

    // Bus source priority resolves accidental multi-drive deterministically.
    always_comb begin
        bus = '0;
        if (Rout || BAout)  bus = reg_val;
        else if (HIout)     bus = hi_q;
        else if (LOout)     bus = lo_q;
        else if (Zhighout)  bus = z_q[Z_W-1:DATA_W];
        else if (Zlowout)   bus = z_q[DATA_W-1:0];
        else if (PCout)     bus = pc_q;
        else if (MDRout)    bus = mdr_q;
        else if (InPortout) bus = inport_q;
        else if (Cout)      bus = c_sext;
    end

    assign mdr_d = read ? mem_out_q : bus;

    data_path_alu u_alu (
        .y_i      (y_q),
        .bus_i    (bus),
        .opcode_i (opcode),
        .inc_pc_i (IncPC),
        .z_o      (alu_z)
    );

    // Mid-step register loads
    always_ff @(negedge clock or negedge clear) begin
        if (!clear) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                rf_q[i] <= '0;
            end
            pc_q  <= '0;
            ir_q  <= '0;
            mar_q <= '0;
            mdr_q <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
            y_q   <= '0;
            z_q   <= '0;
        end else begin
            if (Rin)   rf_q[sel] <= bus;
            if (PCin)  pc_q      <= bus;
            if (IRin)  ir_q      <= bus;
            if (MARin) mar_q     <= bus;
            if (MDRin) mdr_q     <= mdr_d;
            if (HIin)  hi_q      <= bus;
            if (LOin)  lo_q      <= bus;
            if (Yin)   y_q       <= bus;
            if (Zin)   z_q       <= alu_z;
        end
    end

    // Step-start actions: input port capture and RAM output register
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            inport_q  <= '0;
            mem_out_q <= '0;
        end else begin
            if (Strobe) inport_q  <= Inport_In;
            if (read)   mem_out_q <= mem[addr];
        end
    end

    // RAM contents survive reset.
    always @(posedge clock) begin
        if (write) mem[addr] <= mdr_q;
    end

    // Elaboration-time program image.
    initial begin
        if (INIT_FILE != "") begin
            for (int i = 0; i < MEM_DEPTH; i++) begin
                mem[i] = '0;
            end
            mem[0] = 32'hB1800000;
        end
    end

endmodule

// File: tb/tb_data_path.sv
module tb_data_path;

    logic        clock = 1'b0;
    logic        clear;
    logic        read, write;
    logic        Gra, Grb, Grc, Rin, Rout, BAout;
    logic        HIin, HIout, LOin, LOout;
    logic        Zin, Zhighout, Zlowout, Yin;
    logic        MDRin, MDRout, MARin;
    logic        PCin, PCout, IRin, IncPC, Cout;
    logic [4:0]  opcode;
    logic [31:0] Inport_In;
    logic        Strobe, InPortout;

    int tests = 0;
    int fails = 0;

    always #5 clock = ~clock;

    data_path #(.MEM_DEPTH(512), .INIT_FILE("")) dut (
        .clock(clock), .clear(clear), .read(read), .write(write),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
        .HIin(HIin), .HIout(HIout), .LOin(LOin), .LOout(LOout),
        .Zin(Zin), .Zhighout(Zhighout), .Zlowout(Zlowout), .Yin(Yin),
        .MDRin(MDRin), .MDRout(MDRout), .MARin(MARin),
        .PCin(PCin), .PCout(PCout), .IRin(IRin), .IncPC(IncPC), .Cout(Cout),
        .opcode(opcode), .Inport_In(Inport_In),
        .Strobe(Strobe), .InPortout(InPortout)
    );

    task automatic idle();
        read = 0; write = 0; Gra = 0; Grb = 0; Grc = 0; Rin = 0; Rout = 0; BAout = 0;
        HIin = 0; HIout = 0; LOin = 0; LOout = 0; Zin = 0; Zhighout = 0; Zlowout = 0;
        Yin = 0; MDRin = 0; MDRout = 0; MARin = 0; PCin = 0; PCout = 0; IRin = 0;
        IncPC = 0; Cout = 0; Strobe = 0; InPortout = 0;
    endtask

    // One control step: rising edge (RAM, in-port), falling edge (loads).
    task automatic step();
        @(posedge clock);
        @(negedge clock);
        #1;
    endtask

    // Put a value on the bus through the input port during the next step.
    task automatic drive_in(input logic [31:0] v);
        Inport_In = v; Strobe = 1; InPortout = 1;
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic load_y(input logic [31:0] v);
        idle(); drive_in(v); Yin = 1; step();
    endtask

    task automatic alu_op(input logic [4:0] op, input logic [31:0] b);
        idle(); drive_in(b); opcode = op; Zin = 1; step();
    endtask

    initial begin
        idle();
        opcode = 5'b00000;
        Inport_In = 32'h0;
        clear = 0;
        #3;
        chk32("reset_pc", dut.pc_q, 32'h0);
        chk64("reset_z", dut.z_q, 64'h0);
        #9 clear = 1;

        // Place the "in R3" instruction at RAM word 0 through MDR.
        idle(); drive_in(32'hB1800000); MDRin = 1; step();
        idle(); MARin = 1; step();
        idle(); write = 1; step();

        // Fill several registers, then reset mid-operation.
        idle(); drive_in(32'h00000055); PCin = 1; IRin = 1; Yin = 1; HIin = 1; LOin = 1;
        Zin = 1; opcode = 5'b00011; Gra = 1; Rin = 1; step();
        chk32("pre_clear_pc", dut.pc_q, 32'h55);
        chk64("pre_clear_z", dut.z_q, 64'h55);
        idle();
        #1 clear = 0;
        #1;
        chk32("clr_pc", dut.pc_q, 32'h0);
        chk32("clr_ir", dut.ir_q, 32'h0);
        chk32("clr_mdr", dut.mdr_q, 32'h0);
        chk32("clr_y", dut.y_q, 32'h0);
        chk32("clr_hi", dut.hi_q, 32'h0);
        chk32("clr_lo", dut.lo_q, 32'h0);
        chk64("clr_z", dut.z_q, 64'h0);
        chk32("clr_r0", dut.rf_q[0], 32'h0);
        chk32("clr_inport", dut.inport_q, 32'h0);
        chk32("ram_kept", dut.mem[0], 32'hB1800000);
        clear = 1;

        // Fetch from PC=0; opcode set to sub to show IncPC overrides it.
        idle(); opcode = 5'b00100; PCout = 1; MARin = 1; IncPC = 1; Zin = 1; read = 1; step();
        chk64("t0_z", dut.z_q, 64'h1);
        idle(); Zlowout = 1; PCin = 1; MDRin = 1; read = 1; step();
        chk32("t1_mdr", dut.mdr_q, 32'hB1800000);
        idle(); MDRout = 1; IRin = 1; step();
        chk32("fetch_ir", dut.ir_q, 32'hB1800000);
        chk32("fetch_pc", dut.pc_q, 32'h1);

        // in R3
        idle(); drive_in(32'hDEADBEEF); Gra = 1; Rin = 1; step();
        chk32("in_r3", dut.rf_q[3], 32'hDEADBEEF);

        // ALU through Y and Z
        load_y(32'h5);
        alu_op(5'b00011, 32'h3);        chk64("add", dut.z_q, 64'h8);
        alu_op(5'b00100, 32'h3);        chk64("sub", dut.z_q, 64'h2);
        alu_op(5'b10000, 32'hFFFFFFFE); chk64("mul", dut.z_q, 64'hFFFFFFFF_FFFFFFF6);
        load_y(32'h7);
        alu_op(5'b01111, 32'h2);        chk64("div", dut.z_q, 64'h00000001_00000003);
        alu_op(5'b01111, 32'h0);        chk64("div0", dut.z_q, 64'h0);
        load_y(32'hFFFFFFF9);
        alu_op(5'b01111, 32'h2);        chk64("div_neg", dut.z_q, 64'hFFFFFFFF_FFFFFFFD);
        load_y(32'h80000000);
        alu_op(5'b01010, 32'h4);        chk64("shra", dut.z_q, 64'h00000000_F8000000);
        alu_op(5'b01001, 32'h4);        chk64("shr", dut.z_q, 64'h00000000_08000000);
        load_y(32'h80000001);
        alu_op(5'b01000, 32'h1);        chk64("rol", dut.z_q, 64'h3);
        alu_op(5'b00111, 32'h1);        chk64("ror", dut.z_q, 64'hC0000000);
        alu_op(5'b11111, 32'h1);        chk64("unknown_op_add", dut.z_q, 64'h80000002);
        alu_op(5'b10001, 32'h1);        chk64("neg", dut.z_q, 64'hFFFFFFFF);

        // BAout: IR=0 so every field selects R0, which holds 0x1234.
        idle(); drive_in(32'h0); IRin = 1; step();
        idle(); drive_in(32'h1234); Gra = 1; Rin = 1; step();
        idle(); Grb = 1; BAout = 1; #1;
        chk32("baout_r0", dut.bus, 32'h0);
        idle(); Grb = 1; Rout = 1; #1;
        chk32("rout_r0", dut.bus, 32'h1234);
        idle(); HIout = 1; Grb = 1; Rout = 1; #1;
        chk32("bus_priority", dut.bus, 32'h1234);

        // Cout sign extension
        idle(); drive_in(32'h0007FFFF); IRin = 1; step();
        idle(); Cout = 1; #1;
        chk32("cout_neg", dut.bus, 32'hFFFFFFFF);
        idle(); drive_in(32'h0003FFFF); IRin = 1; step();
        idle(); Cout = 1; #1;
        chk32("cout_pos", dut.bus, 32'h0003FFFF);
        idle(); #1;
        chk32("bus_idle", dut.bus, 32'h0);

        // Memory write then read back
        idle(); drive_in(32'h10); MARin = 1; step();
        idle(); drive_in(32'hCAFEF00D); MDRin = 1; step();
        idle(); write = 1; step();
        idle(); drive_in(32'h0); MDRin = 1; step();
        chk32("mdr_clobber", dut.mdr_q, 32'h0);
        idle(); read = 1; MDRin = 1; step();
        chk32("mem_read", dut.mdr_q, 32'hCAFEF00D);

        idle();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
